// File: rtl/collider_sweep_engine.sv
// Per-frame collision sweep over an object table: one slot per cycle, lowest-index attack hit / ground platform wins.
// Optional: define COLLIDER_DESTROY_ON_HIT_EN to kill the hit attack slot in the DONE cycle.
module collider_sweep_engine #(
  parameter int OBJ_COUNT = 20,
  parameter int POS_W     = 10,
  parameter int TIME_W    = 8,
  localparam int IDX_W    = $clog2(OBJ_COUNT)
) (
  input  logic                 clk,
  input  logic                 clk_reset_n,
  input  logic                 start,
  input  logic                 tick_centi,
  input  logic                 obj_wr_en,
  input  logic [IDX_W-1:0]     obj_wr_idx,
  input  logic                 obj_wr_type,
  input  logic [POS_W-1:0]     obj_wr_x1,
  input  logic [POS_W-1:0]     obj_wr_y1,
  input  logic [POS_W-1:0]     obj_wr_x2,
  input  logic [POS_W-1:0]     obj_wr_y2,
  input  logic [TIME_W-1:0]    obj_wr_life,
  input  logic                 obj_clr_en,
  input  logic [IDX_W-1:0]     obj_clr_idx,
  input  logic [POS_W-1:0]     player_x,
  input  logic [POS_W-1:0]     player_y,
  input  logic [POS_W-1:0]     player_w,
  input  logic [POS_W-1:0]     player_h,
  output logic                 busy,
  output logic                 done,
  output logic                 hit_attack,
  output logic [IDX_W-1:0]     hit_idx,
  output logic                 is_ground,
  output logic [POS_W-1:0]     ground_h,
  output logic [OBJ_COUNT-1:0] object_ready_state,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 table_full
);

`ifdef COLLIDER_DESTROY_ON_HIT_EN
  localparam bit DESTROY_ON_HIT = 1'b1;
`else
  localparam bit DESTROY_ON_HIT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [OBJ_COUNT-1:0]  alive_q, alive_d;
  logic [OBJ_COUNT-1:0]  type_q, type_d;
  logic [POS_W-1:0]      x1_q [OBJ_COUNT];
  logic [POS_W-1:0]      x1_d [OBJ_COUNT];
  logic [POS_W-1:0]      y1_q [OBJ_COUNT];
  logic [POS_W-1:0]      y1_d [OBJ_COUNT];
  logic [POS_W-1:0]      x2_q [OBJ_COUNT];
  logic [POS_W-1:0]      x2_d [OBJ_COUNT];
  logic [POS_W-1:0]      y2_q [OBJ_COUNT];
  logic [POS_W-1:0]      y2_d [OBJ_COUNT];
  logic [TIME_W-1:0]     life_q [OBJ_COUNT];
  logic [TIME_W-1:0]     life_d [OBJ_COUNT];
  logic [POS_W-1:0]      px1_q, px1_d, py1_q, py1_d;
  logic [POS_W:0]        px2_q, px2_d, py2_q, py2_d;
  logic                  cmp_hit_q, cmp_hit_d, cmp_gnd_q, cmp_gnd_d;
  logic [IDX_W-1:0]      cmp_idx_q, cmp_idx_d;
  logic [POS_W-1:0]      cmp_y1_q, cmp_y1_d;
  logic                  acc_hit_q, acc_hit_d, acc_gnd_q, acc_gnd_d;
  logic [IDX_W-1:0]      acc_hit_idx_q, acc_hit_idx_d;
  logic [POS_W-1:0]      acc_gnd_h_q, acc_gnd_h_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  hit_attack_q, hit_attack_d, is_ground_q, is_ground_d;
  logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;
  logic [POS_W-1:0]      ground_h_q, ground_h_d;

  logic                  destroy;
  logic                  cur_alive, cur_type, h_ovl, v_ovl, gnd_band;
  logic [POS_W-1:0]      cur_x1, cur_y1, cur_x2, cur_y2;
  logic [POS_W:0]        y1_plus2;

  assign destroy   = DESTROY_ON_HIT && (state_q == S_DONE) && hit_attack_q;
  assign cur_alive = alive_q[scan_idx_q];
  assign cur_type  = type_q[scan_idx_q];
  assign cur_x1    = x1_q[scan_idx_q];
  assign cur_y1    = y1_q[scan_idx_q];
  assign cur_x2    = x2_q[scan_idx_q];
  assign cur_y2    = y2_q[scan_idx_q];

  // Edges use strict compares so touching boxes never count; player far edges are one bit wider to avoid wrap.
  assign h_ovl    = ({1'b0, px1_q} < {1'b0, cur_x2}) && ({1'b0, cur_x1} < px2_q);
  assign v_ovl    = ({1'b0, py1_q} < {1'b0, cur_y2}) && ({1'b0, cur_y1} < py2_q);
  assign y1_plus2 = {1'b0, cur_y1} + (POS_W+1)'(2);
  assign gnd_band = ({1'b0, cur_y1} <= py2_q) && (py2_q <= y1_plus2);

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    alive_d       = alive_q;
    type_d        = type_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    x2_d          = x2_q;
    y2_d          = y2_q;
    life_d        = life_q;
    px1_d         = px1_q;
    py1_d         = py1_q;
    px2_d         = px2_q;
    py2_d         = py2_q;
    acc_hit_d     = acc_hit_q;
    acc_hit_idx_d = acc_hit_idx_q;
    acc_gnd_d     = acc_gnd_q;
    acc_gnd_h_d   = acc_gnd_h_q;
    hit_attack_d  = hit_attack_q;
    hit_idx_d     = hit_idx_q;
    is_ground_d   = is_ground_q;
    ground_h_d    = ground_h_q;

    // Slot table: write beats clear/destroy, which beat lifetime expiry.
    for (int i = 0; i < OBJ_COUNT; i++) begin
      if (obj_wr_en && obj_wr_idx == IDX_W'(i)) begin
        alive_d[i] = 1'b1;
        type_d[i]  = obj_wr_type;
        x1_d[i]    = obj_wr_x1;
        y1_d[i]    = obj_wr_y1;
        x2_d[i]    = obj_wr_x2;
        y2_d[i]    = obj_wr_y2;
        life_d[i]  = obj_wr_life;
      end else if ((obj_clr_en && obj_clr_idx == IDX_W'(i)) || (destroy && hit_idx_q == IDX_W'(i))) begin
        alive_d[i] = 1'b0;
        life_d[i]  = '0;
      end else if (tick_centi && alive_q[i] && life_q[i] != '0) begin
        if (life_q[i] == TIME_W'(1)) begin
          alive_d[i] = 1'b0;
          life_d[i]  = '0;
        end else begin
          life_d[i] = life_q[i] - TIME_W'(1);
        end
      end
    end

    cmp_hit_d = (state_q == S_SCAN) && cur_alive && !cur_type && h_ovl && v_ovl;
    cmp_gnd_d = (state_q == S_SCAN) && cur_alive && cur_type && h_ovl && gnd_band;
    cmp_idx_d = scan_idx_q;
    cmp_y1_d  = cur_y1;

    // Retire the registered compare; the first hit seen is the lowest slot index.
    if (cmp_hit_q && !acc_hit_q) begin
      acc_hit_d     = 1'b1;
      acc_hit_idx_d = cmp_idx_q;
    end
    if (cmp_gnd_q && !acc_gnd_q) begin
      acc_gnd_d   = 1'b1;
      acc_gnd_h_d = cmp_y1_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LATCH;
      end
      S_LATCH: begin
        px1_d         = player_x;
        py1_d         = player_y;
        px2_d         = {1'b0, player_x} + {1'b0, player_w};
        py2_d         = {1'b0, player_y} + {1'b0, player_h};
        acc_hit_d     = 1'b0;
        acc_hit_idx_d = '0;
        acc_gnd_d     = 1'b0;
        acc_gnd_h_d   = '0;
        scan_idx_d    = '0;
        state_d       = S_SCAN;
      end
      S_SCAN: begin
        if (scan_idx_q == IDX_W'(OBJ_COUNT - 1)) state_d = S_DRAIN;
        else scan_idx_d = scan_idx_q + IDX_W'(1);
      end
      S_DRAIN: begin
        hit_attack_d = acc_hit_d;
        hit_idx_d    = acc_hit_idx_d;
        is_ground_d  = acc_gnd_d;
        ground_h_d   = acc_gnd_h_d;
        state_d      = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state_q       <= S_IDLE;
      scan_idx_q    <= '0;
      alive_q       <= '0;
      type_q        <= '0;
      for (int i = 0; i < OBJ_COUNT; i++) begin
        x1_q[i]   <= '0;
        y1_q[i]   <= '0;
        x2_q[i]   <= '0;
        y2_q[i]   <= '0;
        life_q[i] <= '0;
      end
      px1_q         <= '0;
      py1_q         <= '0;
      px2_q         <= '0;
      py2_q         <= '0;
      cmp_hit_q     <= 1'b0;
      cmp_gnd_q     <= 1'b0;
      cmp_idx_q     <= '0;
      cmp_y1_q      <= '0;
      acc_hit_q     <= 1'b0;
      acc_hit_idx_q <= '0;
      acc_gnd_q     <= 1'b0;
      acc_gnd_h_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_attack_q  <= 1'b0;
      hit_idx_q     <= '0;
      is_ground_q   <= 1'b0;
      ground_h_q    <= '0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      alive_q       <= alive_d;
      type_q        <= type_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      x2_q          <= x2_d;
      y2_q          <= y2_d;
      life_q        <= life_d;
      px1_q         <= px1_d;
      py1_q         <= py1_d;
      px2_q         <= px2_d;
      py2_q         <= py2_d;
      cmp_hit_q     <= cmp_hit_d;
      cmp_gnd_q     <= cmp_gnd_d;
      cmp_idx_q     <= cmp_idx_d;
      cmp_y1_q      <= cmp_y1_d;
      acc_hit_q     <= acc_hit_d;
      acc_hit_idx_q <= acc_hit_idx_d;
      acc_gnd_q     <= acc_gnd_d;
      acc_gnd_h_q   <= acc_gnd_h_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hit_attack_q  <= hit_attack_d;
      hit_idx_q     <= hit_idx_d;
      is_ground_q   <= is_ground_d;
      ground_h_q    <= ground_h_d;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = OBJ_COUNT - 1; i >= 0; i--) begin
      if (!alive_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign table_full         = &alive_q;
  assign object_ready_state = alive_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign hit_attack         = hit_attack_q;
  assign hit_idx            = hit_idx_q;
  assign is_ground          = is_ground_q;
  assign ground_h           = ground_h_q;

endmodule

// File: tb/tb_collider_sweep_engine.sv
// Directed plus randomized bench for collider_sweep_engine against a cycle-counted rule model.
module tb_collider_sweep_engine;

  localparam int N      = 20;
  localparam int POS_W  = 10;
  localparam int TIME_W = 8;
  localparam int IDX_W  = $clog2(N);
`ifdef COLLIDER_DESTROY_ON_HIT_EN
  localparam bit DESTROY = 1'b1;
`else
  localparam bit DESTROY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clk_reset_n;
  logic              start, tick_centi, obj_wr_en, obj_wr_type, obj_clr_en;
  logic [IDX_W-1:0]  obj_wr_idx, obj_clr_idx;
  logic [POS_W-1:0]  obj_wr_x1, obj_wr_y1, obj_wr_x2, obj_wr_y2;
  logic [TIME_W-1:0] obj_wr_life;
  logic [POS_W-1:0]  player_x, player_y, player_w, player_h;
  logic              busy, done, hit_attack, is_ground, table_full;
  logic [IDX_W-1:0]  hit_idx, free_idx;
  logic [POS_W-1:0]  ground_h;
  logic [N-1:0]      object_ready_state;

  collider_sweep_engine #(.OBJ_COUNT(N), .POS_W(POS_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .clk_reset_n(clk_reset_n), .start(start), .tick_centi(tick_centi),
    .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx), .obj_wr_type(obj_wr_type),
    .obj_wr_x1(obj_wr_x1), .obj_wr_y1(obj_wr_y1), .obj_wr_x2(obj_wr_x2), .obj_wr_y2(obj_wr_y2),
    .obj_wr_life(obj_wr_life), .obj_clr_en(obj_clr_en), .obj_clr_idx(obj_clr_idx),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .busy(busy), .done(done), .hit_attack(hit_attack), .hit_idx(hit_idx),
    .is_ground(is_ground), .ground_h(ground_h), .object_ready_state(object_ready_state),
    .free_idx(free_idx), .table_full(table_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: slot table, sweep phase counted in cycles since start, published results.
  bit m_alive [N];
  bit m_type  [N];
  int m_x1 [N], m_y1 [N], m_x2 [N], m_y2 [N], m_life [N];
  int m_cyc;
  int l_px1, l_py1, l_px2, l_py2;
  bit r_hit, r_gnd;
  int r_hit_idx, r_gnd_h;
  bit exp_busy, exp_done, exp_hit, exp_gnd;
  int exp_hit_idx, exp_gnd_h;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 0; m_type[i] = 0; m_life[i] = 0;
      m_x1[i] = 0; m_y1[i] = 0; m_x2[i] = 0; m_y2[i] = 0;
    end
    m_cyc = 0;
    r_hit = 0; r_gnd = 0; r_hit_idx = 0; r_gnd_h = 0;
    exp_busy = 0; exp_done = 0; exp_hit = 0; exp_gnd = 0; exp_hit_idx = 0; exp_gnd_h = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic modelCycle();
    int nc;
    bit destroy, hov;
    destroy = DESTROY && (m_cyc == N + 3) && exp_hit;
    nc = m_cyc;
    if (m_cyc == 0) begin
      nc = start ? 1 : 0;
    end else if (m_cyc == 1) begin
      l_px1 = int'(player_x); l_py1 = int'(player_y);
      l_px2 = int'(player_x) + int'(player_w);
      l_py2 = int'(player_y) + int'(player_h);
      r_hit = 0; r_gnd = 0; r_hit_idx = 0; r_gnd_h = 0;
      nc = 2;
    end else if (m_cyc <= N + 1) begin
      int k;
      k = m_cyc - 2;
      if (m_alive[k]) begin
        hov = (l_px1 < m_x2[k]) && (m_x1[k] < l_px2);
        if (!m_type[k] && hov && l_py1 < m_y2[k] && m_y1[k] < l_py2 && !r_hit) begin
          r_hit = 1; r_hit_idx = k;
        end
        if (m_type[k] && hov && m_y1[k] <= l_py2 && l_py2 <= m_y1[k] + 2 && !r_gnd) begin
          r_gnd = 1; r_gnd_h = m_y1[k];
        end
      end
      nc = m_cyc + 1;
    end else if (m_cyc == N + 2) begin
      exp_hit = r_hit; exp_hit_idx = r_hit_idx; exp_gnd = r_gnd; exp_gnd_h = r_gnd_h;
      nc = N + 3;
    end else begin
      nc = 0;
    end
    m_cyc = nc;
    exp_busy = (nc != 0);
    exp_done = (nc == N + 3);
    for (int i = 0; i < N; i++) begin
      if (obj_wr_en && int'(obj_wr_idx) == i) begin
        m_alive[i] = 1; m_type[i] = obj_wr_type; m_life[i] = int'(obj_wr_life);
        m_x1[i] = int'(obj_wr_x1); m_y1[i] = int'(obj_wr_y1);
        m_x2[i] = int'(obj_wr_x2); m_y2[i] = int'(obj_wr_y2);
      end else if ((obj_clr_en && int'(obj_clr_idx) == i) || (destroy && exp_hit_idx == i)) begin
        m_alive[i] = 0; m_life[i] = 0;
      end else if (tick_centi && m_alive[i] && m_life[i] > 0) begin
        m_life[i]--;
        if (m_life[i] == 0) m_alive[i] = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    logic [N-1:0] ea;
    int ef;
    ea = '0; ef = 0;
    for (int i = N - 1; i >= 0; i--) begin
      ea[i] = m_alive[i];
      if (!m_alive[i]) ef = i;
    end
    checkOutput({tag, ".busy"}, busy, exp_busy);
    checkOutput({tag, ".done"}, done, exp_done);
    checkOutput({tag, ".hit_attack"}, hit_attack, exp_hit);
    checkOutput({tag, ".hit_idx"}, hit_idx, exp_hit_idx);
    checkOutput({tag, ".is_ground"}, is_ground, exp_gnd);
    checkOutput({tag, ".ground_h"}, ground_h, exp_gnd_h);
    checkOutput({tag, ".alive"}, object_ready_state, ea);
    checkOutput({tag, ".free_idx"}, free_idx, ef);
    checkOutput({tag, ".table_full"}, table_full, &ea);
  endtask

  // One clock: model update, edge, strobes released, full output check.
  task automatic applyStimulus(input string tag);
    modelCycle();
    @(posedge clk);
    #1;
    start = 0; tick_centi = 0; obj_wr_en = 0; obj_clr_en = 0;
    checkAll(tag);
  endtask

  task automatic writeSlot(input int idx, input bit typ, input int x1, input int y1,
                           input int x2, input int y2, input int life);
    obj_wr_en = 1; obj_wr_idx = IDX_W'(idx); obj_wr_type = typ;
    obj_wr_x1 = POS_W'(x1); obj_wr_y1 = POS_W'(y1);
    obj_wr_x2 = POS_W'(x2); obj_wr_y2 = POS_W'(y2);
    obj_wr_life = TIME_W'(life);
    applyStimulus("write");
  endtask

  task automatic setPlayer(input int x, input int y, input int w, input int h);
    player_x = POS_W'(x); player_y = POS_W'(y); player_w = POS_W'(w); player_h = POS_W'(h);
  endtask

  task automatic runSweep(input string tag);
    int lat, busyCnt;
    lat = 0; busyCnt = 0;
    start = 1;
    applyStimulus(tag);
    for (int c = 1; c <= N + 10; c++) begin
      if (busy) busyCnt++;
      if (done) begin
        lat = c;
        break;
      end
      applyStimulus(tag);
    end
    checkOutput({tag, ".done_latency"}, lat, N + 3);
    checkOutput({tag, ".busy_cycles"}, busyCnt, N + 3);
  endtask

  task automatic randWrite();
    int idx, x1, y1, x2, y2, life, py2;
    bit typ;
    idx = $urandom_range(0, N - 1);
    typ = $urandom_range(0, 1);
    x1 = $urandom_range(0, 300); x2 = x1 + $urandom_range(1, 120);
    y1 = $urandom_range(0, 300); y2 = y1 + $urandom_range(1, 120);
    py2 = int'(player_y) + int'(player_h);
    if (typ && $urandom_range(0, 1) == 1) begin
      y1 = py2 - $urandom_range(0, 3);
      if (y1 < 0) y1 = 0;
      if (y1 > 1000) y1 = 1000;
      y2 = y1 + 5;
    end
    life = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
    obj_wr_en = 1; obj_wr_idx = IDX_W'(idx); obj_wr_type = typ;
    obj_wr_x1 = POS_W'(x1); obj_wr_y1 = POS_W'(y1);
    obj_wr_x2 = POS_W'(x2); obj_wr_y2 = POS_W'(y2);
    obj_wr_life = TIME_W'(life);
  endtask

  task automatic randStrobes(input bit allow_start);
    if ($urandom_range(0, 3) == 0) randWrite();
    if ($urandom_range(0, 5) == 0) begin
      obj_clr_en = 1; obj_clr_idx = IDX_W'($urandom_range(0, N - 1));
    end
    if ($urandom_range(0, 2) == 0) tick_centi = 1;
    if (allow_start && $urandom_range(0, 7) == 0) start = 1;
  endtask

  initial begin
    clk_reset_n = 0;
    start = 0; tick_centi = 0; obj_wr_en = 0; obj_clr_en = 0; obj_wr_type = 0;
    obj_wr_idx = '0; obj_clr_idx = '0; obj_wr_life = '0;
    obj_wr_x1 = '0; obj_wr_y1 = '0; obj_wr_x2 = '0; obj_wr_y2 = '0;
    setPlayer(0, 0, 0, 0);
    modelReset();
    #3;
    checkAll("reset");
    @(posedge clk); #1;
    clk_reset_n = 1;

    // Basic attack hit on slot 3
    writeSlot(3, 0, 100, 100, 120, 120, 0);
    setPlayer(110, 110, 8, 8);
    runSweep("hit3");
    checkOutput("hit3.flag", hit_attack, 1);
    checkOutput("hit3.idx", hit_idx, 3);
    applyStimulus("hit3.after");

    // Touching right edge of player onto attack x1 is not a hit
    setPlayer(80, 100, 20, 10);
    runSweep("edge");
    checkOutput("edge.flag", hit_attack, 0);
    checkOutput("edge.idx", hit_idx, 0);
    applyStimulus("edge.after");

    // Two platforms under the player, lower slot index wins
    writeSlot(5, 1, 50, 200, 150, 210, 0);
    writeSlot(2, 1, 50, 201, 150, 211, 0);
    setPlayer(60, 191, 10, 10);
    runSweep("ground");
    checkOutput("ground.flag", is_ground, 1);
    checkOutput("ground.h", ground_h, 201);
    applyStimulus("ground.after");

    // Lifetime expiry of slot 7 with slots 0..6 alive
    writeSlot(0, 0, 900, 900, 950, 950, 0);
    writeSlot(1, 0, 900, 900, 950, 950, 0);
    writeSlot(3, 0, 100, 100, 120, 120, 0);
    writeSlot(4, 0, 900, 900, 950, 950, 0);
    writeSlot(6, 0, 900, 900, 950, 950, 0);
    writeSlot(7, 1, 900, 900, 950, 950, 3);
    checkOutput("life.t0", object_ready_state[7], 1);
    checkOutput("life.free_t0", free_idx, 8);
    tick_centi = 1; applyStimulus("tick1");
    checkOutput("life.t1", object_ready_state[7], 1);
    tick_centi = 1; applyStimulus("tick2");
    checkOutput("life.t2", object_ready_state[7], 1);
    tick_centi = 1; applyStimulus("tick3");
    checkOutput("life.t3", object_ready_state[7], 0);
    checkOutput("life.free_t3", free_idx, 7);
    checkOutput("life.persist0", object_ready_state[0], 1);

    // Write and expiry on slot 4 in the same cycle: write wins
    writeSlot(4, 0, 900, 900, 950, 950, 1);
    tick_centi = 1;
    writeSlot(4, 0, 900, 900, 950, 950, 5);
    checkOutput("wrtick.alive", object_ready_state[4], 1);
    for (int t = 0; t < 4; t++) begin
      tick_centi = 1; applyStimulus("wrtick.tick");
    end
    checkOutput("wrtick.alive4", object_ready_state[4], 1);
    tick_centi = 1; applyStimulus("wrtick.tick5");
    checkOutput("wrtick.dead", object_ready_state[4], 0);

    // Reset mid-SCAN abandons the sweep
    start = 1; applyStimulus("midscan");
    for (int c = 0; c < 6; c++) applyStimulus("midscan");
    clk_reset_n = 0;
    #1;
    modelReset();
    checkAll("midreset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkAll("inreset");
    end
    clk_reset_n = 1;
    for (int c = 0; c < N + 6; c++) applyStimulus("postreset");
    checkOutput("postreset.done", done, 0);

    // Destroy-on-hit behaviour across two sweeps
    writeSlot(3, 0, 100, 100, 120, 120, 0);
    setPlayer(110, 110, 8, 8);
    runSweep("sweep1");
    checkOutput("sweep1.flag", hit_attack, 1);
    checkOutput("sweep1.idx", hit_idx, 3);
    applyStimulus("sweep1.after");
    checkOutput("sweep1.alive3", object_ready_state[3], DESTROY ? 0 : 1);
    runSweep("sweep2");
    checkOutput("sweep2.flag", hit_attack, DESTROY ? 0 : 1);
    applyStimulus("sweep2.after");

    // Randomized traffic including table activity during sweeps and ignored start pulses
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0)
        setPlayer($urandom_range(900, 1023), $urandom_range(0, 300), $urandom_range(0, 127), $urandom_range(0, 100));
      else
        setPlayer($urandom_range(0, 350), $urandom_range(0, 350), $urandom_range(0, 100), $urandom_range(0, 100));
      for (int c = 0; c < 12; c++) begin
        randStrobes(1'b0);
        applyStimulus("rand.idle");
      end
      start = 1;
      applyStimulus("rand.start");
      for (int c = 0; c < N + 4; c++) begin
        randStrobes(1'b1);
        applyStimulus("rand.sweep");
      end
      for (int c = 0; c < 4; c++) applyStimulus("rand.settle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
